// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - parametrised coin vending controller with serial change return
module vend_ctrl_param #(
  parameter int PRICE      = 7,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_INIT = 8,
  parameter int STOCK_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_1,
  input  logic                coin_2,
  input  logic                coin_5,
  input  logic                cancel,
  input  logic                restock,
  output logic                dispense,
  output logic                ret_1,
  output logic                ret_2,
  output logic                coin_reject,
  output logic                busy,
  output logic                sold_out,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock
);

  typedef enum logic {IDLE, CHANGE} state_t;

  localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic [STOCK_W-1:0]  stock_nx;
  logic                dispense_nx, ret_1_nx, ret_2_nx, reject_nx;
  logic [2:0]          coins;
  logic                one_coin, coin_ok;
  logic [CREDIT_W:0]   coin_val, sum, diff;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      stock       <= STOCK_W'(STOCK_INIT);
      dispense    <= 1'b0;
      ret_1       <= 1'b0;
      ret_2       <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      stock       <= stock_nx;
      dispense    <= dispense_nx;
      ret_1       <= ret_1_nx;
      ret_2       <= ret_2_nx;
      coin_reject <= reject_nx;
    end
  end

  assign busy     = (state == CHANGE);
  assign sold_out = (stock == '0);

  always_comb begin
    state_nx    = state;
    credit_nx   = credit;
    stock_nx    = stock;
    dispense_nx = 1'b0;
    ret_1_nx    = 1'b0;
    ret_2_nx    = 1'b0;

    coins    = {coin_5, coin_2, coin_1};
    one_coin = (coins == 3'b001) || (coins == 3'b010) || (coins == 3'b100);
    coin_ok  = one_coin && (state == IDLE) && !sold_out && !cancel;
    coin_val = coin_5 ? (CREDIT_W+1)'(5) : (coin_2 ? (CREDIT_W+1)'(2) : (CREDIT_W+1)'(1));
    // One extra bit keeps credit + 5 from wrapping before the price compare.
    sum       = {1'b0, credit} + coin_val;
    diff      = sum - PRICE_X;
    reject_nx = (coins != 3'b000) && !coin_ok;

    case (state)
      IDLE: begin
        if (coin_ok) begin
          if (sum >= PRICE_X) begin
            dispense_nx = 1'b1;
            stock_nx    = stock - STOCK_W'(1);
            credit_nx   = diff[CREDIT_W-1:0];
            if (diff != '0) state_nx = CHANGE;
          end else begin
            credit_nx = sum[CREDIT_W-1:0];
          end
        end else if (cancel && (credit != '0)) begin
          state_nx = CHANGE;
        end
        if (restock) stock_nx = STOCK_W'(STOCK_INIT);
      end
      CHANGE: begin
        // Greedy change: Rs2 coins first, a final Rs1 if the remainder is odd.
        if (credit >= CREDIT_W'(2)) begin
          ret_2_nx  = 1'b1;
          credit_nx = credit - CREDIT_W'(2);
        end else begin
          ret_1_nx  = 1'b1;
          credit_nx = credit - CREDIT_W'(1);
        end
        if (credit_nx == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb/tb_vend_ctrl_param.sv - self-checking bench: directed spec scenarios plus random traffic vs a rupee-level model
module tb_vend_ctrl_param;

  localparam int PRICE = 7;
  localparam int SINIT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coin_1 = 0, coin_2 = 0, coin_5 = 0, cancel = 0, restock = 0;
  logic dispense, ret_1, ret_2, coin_reject, busy, sold_out;
  logic [3:0] credit, stock;

  logic b_c1 = 0, b_c2 = 0, b_c5 = 0, b_can = 0, b_rs = 0;
  logic b_disp, b_r1, b_r2, b_rej, b_busy, b_so;
  logic [3:0] b_credit, b_stock;

  int errors = 0;
  int checks = 0;

  // Reference model state, in whole rupees and items.
  int  m_credit, m_stock;
  bit  m_refunding;
  bit  m_disp, m_r1, m_r2, m_rej;

  always #5 clk = ~clk;

  vend_ctrl_param #(.PRICE(7), .CREDIT_W(4), .STOCK_INIT(8), .STOCK_W(4)) dut (
    .clk(clk), .reset(reset), .coin_1(coin_1), .coin_2(coin_2), .coin_5(coin_5),
    .cancel(cancel), .restock(restock), .dispense(dispense), .ret_1(ret_1), .ret_2(ret_2),
    .coin_reject(coin_reject), .busy(busy), .sold_out(sold_out), .credit(credit), .stock(stock)
  );

  vend_ctrl_param #(.PRICE(7), .CREDIT_W(4), .STOCK_INIT(1), .STOCK_W(4)) dut1 (
    .clk(clk), .reset(reset), .coin_1(b_c1), .coin_2(b_c2), .coin_5(b_c5),
    .cancel(b_can), .restock(b_rs), .dispense(b_disp), .ret_1(b_r1), .ret_2(b_r2),
    .coin_reject(b_rej), .busy(b_busy), .sold_out(b_so), .credit(b_credit), .stock(b_stock)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit c1, input bit c2, input bit c5,
                       input bit can, input bit rs);
    int n, v, s;
    m_disp = 0; m_r1 = 0; m_r2 = 0; m_rej = 0;
    if (rst) begin
      m_credit = 0; m_stock = SINIT; m_refunding = 0;
      return;
    end
    n = int'(c1) + int'(c2) + int'(c5);
    if (m_refunding) begin
      m_rej = (n > 0);
      if (m_credit >= 2) begin m_r2 = 1; m_credit -= 2; end
      else begin m_r1 = 1; m_credit -= 1; end
      m_refunding = (m_credit > 0);
    end else begin
      if (n == 1 && m_stock > 0 && !can) begin
        v = c5 ? 5 : (c2 ? 2 : 1);
        s = m_credit + v;
        if (s >= PRICE) begin
          m_disp = 1; m_stock -= 1; m_credit = s - PRICE;
          m_refunding = (m_credit > 0);
        end else begin
          m_credit = s;
        end
      end else begin
        m_rej = (n > 0);
        if (can && m_credit > 0) m_refunding = 1;
      end
      if (rs) m_stock = SINIT;
    end
  endtask

  task automatic step(input string tag, input bit rst, input bit c1, input bit c2,
                      input bit c5, input bit can, input bit rs);
    logic [13:0] obs, exp;
    reset = rst; coin_1 = c1; coin_2 = c2; coin_5 = c5; cancel = can; restock = rs;
    @(posedge clk);
    model(rst, c1, c2, c5, can, rs);
    #1;
    reset = 0; coin_1 = 0; coin_2 = 0; coin_5 = 0; cancel = 0; restock = 0;
    obs = {dispense, ret_1, ret_2, coin_reject, busy, sold_out, credit, stock};
    exp = {m_disp, m_r1, m_r2, m_rej, m_refunding, (m_stock == 0), 4'(m_credit), 4'(m_stock)};
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic bstep(input bit c1, input bit c2, input bit c5, input bit rs);
    b_c1 = c1; b_c2 = c2; b_c5 = c5; b_rs = rs;
    @(posedge clk); #1;
    b_c1 = 0; b_c2 = 0; b_c5 = 0; b_rs = 0;
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    check("rst_credit", 32'(b_credit), 0);
    check("rst_stock1", 32'(b_stock), 1);
    check("rst_pulses", 32'({b_disp, b_r1, b_r2, b_rej, b_busy}), 0);

    // Single-item stock: vend, sold out, reject, restock, accept.
    bstep(0, 0, 1, 0);
    check("so_credit5", 32'(b_credit), 5);
    bstep(0, 1, 0, 0);
    check("so_disp", 32'(b_disp), 1);
    check("so_stock0", 32'(b_stock), 0);
    bstep(0, 0, 0, 0);
    check("so_flag", 32'(b_so), 1);
    bstep(0, 0, 1, 0);
    check("so_reject", 32'(b_rej), 1);
    check("so_rej_credit", 32'(b_credit), 0);
    bstep(0, 0, 0, 1);
    check("restock_stock", 32'(b_stock), 1);
    check("restock_so", 32'(b_so), 0);
    bstep(0, 0, 1, 0);
    check("restock_accept", 32'(b_rej), 0);
    check("restock_credit", 32'(b_credit), 5);

    step("reset", 1, 0, 0, 0, 0, 0);
    check("reset_stock8", 32'(stock), 8);

    // Exact price: Rs2 + Rs5.
    step("t1_c2", 0, 0, 1, 0, 0, 0);
    step("t1_c5", 0, 0, 0, 1, 0, 0);
    check("t1_dispense", 32'(dispense), 1);
    check("t1_stock7", 32'(stock), 7);
    step("t1_idle", 0, 0, 0, 0, 0, 0);
    check("t1_noret", 32'({ret_1, ret_2}), 0);

    // Overpay by 3: Rs2 then Rs1 back.
    step("t2_c5a", 0, 0, 0, 1, 0, 0);
    step("t2_c5b", 0, 0, 0, 1, 0, 0);
    check("t2_busy_disp", 32'({dispense, busy, credit}), 32'h33);
    step("t2_ch1", 0, 0, 0, 0, 0, 0);
    check("t2_ret2", 32'({ret_2, busy}), 32'h3);
    step("t2_ch2", 0, 0, 0, 0, 0, 0);
    check("t2_ret1", 32'({ret_1, busy, credit}), 32'h20);

    // Cancel refund.
    step("t3_reset", 1, 0, 0, 0, 0, 0);
    step("t3_c1", 0, 1, 0, 0, 0, 0);
    step("t3_c2", 0, 0, 1, 0, 0, 0);
    step("t3_cancel", 0, 0, 0, 0, 1, 0);
    step("t3_ch1", 0, 0, 0, 0, 0, 0);
    check("t3_ret2", 32'(ret_2), 1);
    step("t3_ch2", 0, 0, 0, 0, 0, 0);
    check("t3_ret1_stock", 32'({ret_1, dispense, stock}), 32'h28);

    // Coin during change is rejected, change proceeds.
    step("t4_c5a", 0, 0, 0, 1, 0, 0);
    step("t4_c5b", 0, 0, 0, 1, 0, 0);
    step("t4_c2_in_change", 0, 0, 1, 0, 0, 0);
    check("t4_reject", 32'({coin_reject, ret_2}), 32'h3);
    step("t4_ch2", 0, 0, 0, 0, 0, 0);
    check("t4_end_credit", 32'({ret_1, credit}), 32'h10);

    // Two coins in one cycle.
    step("t5_double", 0, 1, 1, 0, 0, 0);
    check("t5_reject", 32'({coin_reject, credit}), 32'h10);

    // Reset in the first change cycle.
    step("t6_c5a", 0, 0, 0, 1, 0, 0);
    step("t6_c5b", 0, 0, 0, 1, 0, 0);
    step("t6_reset", 1, 0, 0, 0, 0, 0);
    check("t6_state", 32'({busy, credit, stock}), 32'h008);
    step("t6_idle1", 0, 0, 0, 0, 0, 0);
    step("t6_idle2", 0, 0, 0, 0, 0, 0);
    check("t6_noret", 32'({ret_1, ret_2}), 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      bit c1, c2, c5, can, rs, rst;
      r = $urandom_range(0, 99);
      c1 = 0; c2 = 0; c5 = 0; can = 0; rs = 0; rst = 0;
      if (r < 15) c1 = 1;
      else if (r < 32) c2 = 1;
      else if (r < 52) c5 = 1;
      else if (r < 57) begin c1 = 1'($urandom); c2 = 1'($urandom); c5 = 1; end
      else if (r < 65) can = 1;
      else if (r < 68) rs = 1;
      else if (r < 72) begin can = 1; c2 = 1; end
      else if (r < 73) rst = 1;
      step("rand", rst, c1, c2, c5, can, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
